ll_multi_queue_engine: RTL and testbench

//  Parametrised linked-list queue engine: NUM_LL independent FIFO lists share one node pool of NODE_DEPTH entries.
//  On-chip free list, built by a walk after reset. Per-list head, tail and count in registers.
//  Ops: push-tail, pop-head, peek-head, flush-list. One request at a time, valid/ready on both request and response.

---
 rtl/ll_multi_queue_engine.sv | 257 +++++++++++++++++++++++++
 tb/tb_ll_multi_queue_engine.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ll_multi_queue_engine.sv
// Linked-list queue engine: NUM_LL FIFO lists threaded through one shared node
// pool, with an on-chip free list built by a walk after reset.
module ll_multi_queue_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NODE_DEPTH = 16,
    parameter int unsigned NUM_LL     = 4,
    localparam int unsigned PTR_W     = $clog2(NODE_DEPTH),
    localparam int unsigned LL_W      = (NUM_LL > 1) ? $clog2(NUM_LL) : 1,
    localparam int unsigned CNT_W     = $clog2(NODE_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  req_vld_i,
    output logic                  req_ready_o,
    input  logic [1:0]            req_op_i,
    input  logic [LL_W-1:0]       req_ll_num_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  resp_vld_o,
    input  logic                  resp_rdy_i,
    output logic [DATA_WIDTH-1:0] resp_data_o,
    output logic [1:0]            resp_err_o,
    output logic [LL_W-1:0]       resp_ll_num_o,
    output logic [CNT_W-1:0]      resp_node_cnt_o,
    output logic [CNT_W-1:0]      free_cnt_o,
    output logic                  init_done_o
);

    localparam logic [1:0] OP_PUSH  = 2'd0;
    localparam logic [1:0] OP_POP   = 2'd1;
    localparam logic [1:0] OP_PEEK  = 2'd2;
    localparam logic [1:0] OP_FLUSH = 2'd3;

    localparam logic [1:0] ERR_OK     = 2'd0;
    localparam logic [1:0] ERR_EMPTY  = 2'd1;
    localparam logic [1:0] ERR_FULL   = 2'd2;
    localparam logic [1:0] ERR_BAD_LL = 2'd3;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      init_idx_q, init_idx_d;
    logic [PTR_W-1:0]      free_hd_q, free_hd_d;
    logic [CNT_W-1:0]      free_cnt_q, free_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [PTR_W-1:0]      head_q [NUM_LL];
    logic [PTR_W-1:0]      head_d [NUM_LL];
    logic [PTR_W-1:0]      tail_q [NUM_LL];
    logic [PTR_W-1:0]      tail_d [NUM_LL];
    logic [CNT_W-1:0]      cnt_q  [NUM_LL];
    logic [CNT_W-1:0]      cnt_d  [NUM_LL];
    logic [1:0]            op_q, op_d;
    logic [LL_W-1:0]       op_ll_q, op_ll_d;
    logic [DATA_WIDTH-1:0] op_data_q, op_data_d;
    logic                  resp_vld_q, resp_vld_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [1:0]            resp_err_q, resp_err_d;
    logic [LL_W-1:0]       resp_ll_q, resp_ll_d;
    logic [CNT_W-1:0]      resp_cnt_q, resp_cnt_d;

    logic [DATA_WIDTH-1:0] data_mem [NODE_DEPTH];
    logic [PTR_W-1:0]      nxt_mem  [NODE_DEPTH];
    logic                  nxt_we, dat_we;
    logic [PTR_W-1:0]      nxt_wa, nxt_wd;
    logic                  ll_ok;
    logic [LL_W-1:0]       ll_idx;
    logic                  init_last;

    assign init_last = (init_idx_q == PTR_W'(NODE_DEPTH - 1));
    assign ll_ok     = (32'(op_ll_q) < NUM_LL);
    assign ll_idx    = ll_ok ? op_ll_q : '0;

    // FSM state register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= S_INIT;
        else         state_q <= state_d;
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT: if (init_last)  state_d = S_IDLE;
            S_IDLE: if (req_vld_i)  state_d = S_EXEC;
            S_EXEC:                 state_d = S_RESP;
            S_RESP: if (resp_rdy_i) state_d = S_IDLE;
            default:                state_d = S_INIT;
        endcase
    end

    // FSM outputs: the engine accepts only while idle
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
    end

    // List manipulation: every read sees pre-op values, every update lands at EXEC exit
    always_comb begin
        init_idx_d  = init_idx_q;
        free_hd_d   = free_hd_q;
        free_cnt_d  = free_cnt_q;
        init_done_d = init_done_q;
        head_d      = head_q;
        tail_d      = tail_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        op_ll_d     = op_ll_q;
        op_data_d   = op_data_q;
        resp_vld_d  = resp_vld_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        resp_ll_d   = resp_ll_q;
        resp_cnt_d  = resp_cnt_q;
        nxt_we      = 1'b0;
        nxt_wa      = '0;
        nxt_wd      = '0;
        dat_we      = 1'b0;
        case (state_q)
            S_INIT: begin
                nxt_we     = 1'b1;
                nxt_wa     = init_idx_q;
                nxt_wd     = init_idx_q + PTR_W'(1);
                init_idx_d = init_idx_q + PTR_W'(1);
                if (init_last) begin
                    free_hd_d   = '0;
                    free_cnt_d  = CNT_W'(NODE_DEPTH);
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (req_vld_i) begin
                    op_d      = req_op_i;
                    op_ll_d   = req_ll_num_i;
                    op_data_d = req_data_i;
                end
            end
            S_EXEC: begin
                resp_vld_d  = 1'b1;
                resp_ll_d   = op_ll_q;
                resp_data_d = '0;
                resp_err_d  = ERR_OK;
                resp_cnt_d  = '0;
                if (!ll_ok) begin
                    resp_err_d = ERR_BAD_LL;
                end else begin
                    case (op_q)
                        OP_PUSH: begin
                            if (free_cnt_q == '0) begin
                                resp_err_d = ERR_FULL;
                            end else begin
                                dat_we    = 1'b1;
                                free_hd_d = nxt_mem[free_hd_q];
                                if (cnt_q[ll_idx] == '0) begin
                                    head_d[ll_idx] = free_hd_q;
                                end else begin
                                    nxt_we = 1'b1;
                                    nxt_wa = tail_q[ll_idx];
                                    nxt_wd = free_hd_q;
                                end
                                tail_d[ll_idx] = free_hd_q;
                                cnt_d[ll_idx]  = cnt_q[ll_idx] + CNT_W'(1);
                                free_cnt_d     = free_cnt_q - CNT_W'(1);
                            end
                        end
                        OP_POP: begin
                            if (cnt_q[ll_idx] == '0) begin
                                resp_err_d = ERR_EMPTY;
                            end else begin
                                resp_data_d    = data_mem[head_q[ll_idx]];
                                head_d[ll_idx] = nxt_mem[head_q[ll_idx]];
                                nxt_we         = 1'b1;
                                nxt_wa         = head_q[ll_idx];
                                nxt_wd         = free_hd_q;
                                free_hd_d      = head_q[ll_idx];
                                cnt_d[ll_idx]  = cnt_q[ll_idx] - CNT_W'(1);
                                free_cnt_d     = free_cnt_q + CNT_W'(1);
                            end
                        end
                        OP_PEEK: begin
                            if (cnt_q[ll_idx] == '0) resp_err_d  = ERR_EMPTY;
                            else                     resp_data_d = data_mem[head_q[ll_idx]];
                        end
                        OP_FLUSH: begin
                            // whole list spliced in front of the free list in one write
                            if (cnt_q[ll_idx] != '0) begin
                                nxt_we        = 1'b1;
                                nxt_wa        = tail_q[ll_idx];
                                nxt_wd        = free_hd_q;
                                free_hd_d     = head_q[ll_idx];
                                free_cnt_d    = free_cnt_q + cnt_q[ll_idx];
                                cnt_d[ll_idx] = '0;
                            end
                        end
                        default: ;
                    endcase
                    resp_cnt_d = cnt_d[ll_idx];
                end
            end
            S_RESP: begin
                if (resp_rdy_i) resp_vld_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Control and list registers
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            init_idx_q  <= '0;
            free_hd_q   <= '0;
            free_cnt_q  <= '0;
            init_done_q <= 1'b0;
            for (int i = 0; i < int'(NUM_LL); i++) begin
                head_q[i] <= '0;
                tail_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            op_q        <= '0;
            op_ll_q     <= '0;
            op_data_q   <= '0;
            resp_vld_q  <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= '0;
            resp_ll_q   <= '0;
            resp_cnt_q  <= '0;
        end else begin
            init_idx_q  <= init_idx_d;
            free_hd_q   <= free_hd_d;
            free_cnt_q  <= free_cnt_d;
            init_done_q <= init_done_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            op_ll_q     <= op_ll_d;
            op_data_q   <= op_data_d;
            resp_vld_q  <= resp_vld_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            resp_ll_q   <= resp_ll_d;
            resp_cnt_q  <= resp_cnt_d;
        end
    end

    // Node pool storage (payload and next pointers), not reset
    always_ff @(posedge clk_i) begin
        if (dat_we) data_mem[free_hd_q] <= op_data_q;
        if (nxt_we) nxt_mem[nxt_wa]     <= nxt_wd;
    end

    assign resp_vld_o      = resp_vld_q;
    assign resp_data_o     = resp_data_q;
    assign resp_err_o      = resp_err_q;
    assign resp_ll_num_o   = resp_ll_q;
    assign resp_node_cnt_o = resp_cnt_q;
    assign free_cnt_o      = free_cnt_q;
    assign init_done_o     = init_done_q;

endmodule

// File: tb/tb_ll_multi_queue_engine.sv
// Bench for ll_multi_queue_engine: a queue-of-queues reference model feeds a
// response scoreboard; a second instance with three lists covers BAD_LL.
module tb_ll_multi_queue_engine;

    localparam int ND = 16;

    typedef struct {
        logic [7:0] data;
        logic [1:0] err;
        logic [1:0] ll;
        logic [4:0] cnt;
        logic [4:0] free;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req_vld, req_ready, resp_vld, resp_rdy, init_done;
    logic [1:0] req_op, req_ll, resp_err, resp_ll;
    logic [7:0] req_data, resp_data;
    logic [4:0] resp_cnt, free_cnt;

    logic       req_vld3, req_ready3, resp_vld3, resp_rdy3, init_done3;
    logic [1:0] req_op3, req_ll3, resp_err3, resp_ll3;
    logic [7:0] req_data3, resp_data3;
    logic [4:0] resp_cnt3, free_cnt3;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] mq[4][$];
    int         vectors = 0;
    int         miscompares = 0;
    int         idle_free_exp = ND;
    int         rdy_mode = 0;

    ll_multi_queue_engine #(.DATA_WIDTH(8), .NODE_DEPTH(ND), .NUM_LL(4)) u_dut (
        .clk_i(clk), .reset_i(reset),
        .req_vld_i(req_vld), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_ll_num_i(req_ll), .req_data_i(req_data),
        .resp_vld_o(resp_vld), .resp_rdy_i(resp_rdy), .resp_data_o(resp_data),
        .resp_err_o(resp_err), .resp_ll_num_o(resp_ll), .resp_node_cnt_o(resp_cnt),
        .free_cnt_o(free_cnt), .init_done_o(init_done)
    );

    ll_multi_queue_engine #(.DATA_WIDTH(8), .NODE_DEPTH(ND), .NUM_LL(3)) u_dut3 (
        .clk_i(clk), .reset_i(reset),
        .req_vld_i(req_vld3), .req_ready_o(req_ready3), .req_op_i(req_op3),
        .req_ll_num_i(req_ll3), .req_data_i(req_data3),
        .resp_vld_o(resp_vld3), .resp_rdy_i(resp_rdy3), .resp_data_o(resp_data3),
        .resp_err_o(resp_err3), .resp_ll_num_o(resp_ll3), .resp_node_cnt_o(resp_cnt3),
        .free_cnt_o(free_cnt3), .init_done_o(init_done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic int model_total();
        int t = 0;
        for (int i = 0; i < 4; i++) t += mq[i].size();
        return t;
    endfunction

    // Reference behaviour: each list is a plain queue, the pool is just a total cap
    function automatic exp_t model(input logic [1:0] op, input int ll, input logic [7:0] d);
        exp_t e;
        e.data = 8'h00;
        e.err  = 2'd0;
        e.ll   = 2'(ll);
        case (op)
            2'd0: if (model_total() == ND) e.err = 2'd2; else mq[ll].push_back(d);
            2'd1: if (mq[ll].size() == 0) e.err = 2'd1; else e.data = mq[ll].pop_front();
            2'd2: if (mq[ll].size() == 0) e.err = 2'd1; else e.data = mq[ll][0];
            default: mq[ll].delete();
        endcase
        e.cnt  = 5'(mq[ll].size());
        e.free = 5'(ND - model_total());
        return e;
    endfunction

    // Response consumer readiness: 0 always ready, 1 random, 2 stalled
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       resp_rdy = 1'b1;
            1:       resp_rdy = 1'($urandom_range(0, 1));
            default: resp_rdy = 1'b0;
        endcase
    end

    // Monitor: pool invariant while idle, scoreboard check on each response handshake
    always @(negedge clk) begin
        if (!reset && init_done) begin
            if (req_ready) chk("idle_free_cnt", 32'(free_cnt), 32'(idle_free_exp));
            if (resp_vld && resp_rdy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("resp_data", 32'(resp_data), 32'(mon_e.data));
                    chk("resp_err",  32'(resp_err),  32'(mon_e.err));
                    chk("resp_ll",   32'(resp_ll),   32'(mon_e.ll));
                    chk("resp_cnt",  32'(resp_cnt),  32'(mon_e.cnt));
                    chk("resp_free", 32'(free_cnt),  32'(mon_e.free));
                    idle_free_exp = int'(mon_e.free);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input int ll, input logic [7:0] d);
        bit ok = 0;
        req_op = op; req_ll = 2'(ll); req_data = d; req_vld = 1'b1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            fail_now("req_accept_timeout");
            req_vld = 1'b0;
            return;
        end
        exp_q.push_back(model(op, ll, d));
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(posedge clk); n++; end
        if (exp_q.size() != 0) begin fail_now("drain_timeout"); exp_q.delete(); end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic issue3(input logic [1:0] op, input logic [1:0] ll, input logic [7:0] d, output bit ok);
        ok = 0;
        req_op3 = op; req_ll3 = ll; req_data3 = d; req_vld3 = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready3) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_vld3 = 1'b0;
        if (!ok) begin fail_now("dut3_accept_timeout"); return; end
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (resp_vld3) begin ok = 1; break; end
        end
        if (!ok) fail_now("dut3_resp_timeout");
    endtask

    initial begin
        bit ok;
        reset = 1'b1; resp_rdy = 1'b1;
        req_vld = 1'b0; req_op = '0; req_ll = '0; req_data = '0;
        req_vld3 = 1'b0; req_op3 = '0; req_ll3 = '0; req_data3 = '0; resp_rdy3 = 1'b1;

        // reset values and INIT timing
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_vld",  32'(resp_vld),  0);
        chk("rst_free_cnt",  32'(free_cnt),  0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_resp_err",  32'(resp_err),  0);
        @(negedge clk);
        reset = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("init_done_early", 32'(init_done), 0);
        chk("req_ready_early", 32'(req_ready), 0);
        @(posedge clk); #1;
        chk("init_done", 32'(init_done), 1);
        chk("init_free", 32'(free_cnt), ND);
        chk("init_ready", 32'(req_ready), 1);

        // basic FIFO order on one list and EMPTY guard
        issue(2'd0, 1, 8'hA1);
        issue(2'd0, 1, 8'hA2);
        repeat (3) issue(2'd1, 1, 8'h00);
        drain();

        // fill pool across LL0/LL3, FULL guard, flush LL3, LL0 intact
        for (int i = 0; i < ND; i++) issue(2'd0, (i % 2) ? 3 : 0, 8'($urandom));
        issue(2'd0, 0, 8'h55);
        issue(2'd3, 3, 8'h00);
        drain();
        chk("free_after_flush", 32'(free_cnt), 8);
        issue(2'd2, 3, 8'h00);
        for (int i = 0; i < 9; i++) issue(2'd1, 0, 8'h00);
        drain();

        // randomized mix across all lists with a randomly stalling consumer
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 19);
            logic [1:0] op;
            if (r < 10)       op = 2'd0;
            else if (r < 16)  op = 2'd1;
            else if (r < 19)  op = 2'd2;
            else              op = 2'd3;
            issue(op, $urandom_range(0, 3), 8'($urandom));
        end
        rdy_mode = 0;
        drain();

        // stalled response stays stable and blocks new requests
        for (int l = 0; l < 4; l++) issue(2'd3, l, 8'h00);
        issue(2'd0, 2, 8'h5C);
        drain();
        rdy_mode = 2; resp_rdy = 1'b0;
        issue(2'd2, 2, 8'h00);
        ok = 0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (resp_vld) begin ok = 1; break; end
        end
        if (!ok) fail_now("hold_resp_timeout");
        for (int c = 0; c < 5; c++) begin
            chk("hold_vld",   32'(resp_vld),  1);
            chk("hold_ready", 32'(req_ready), 0);
            chk("hold_data",  32'(resp_data), 32'h5C);
            chk("hold_err",   32'(resp_err),  0);
            chk("hold_cnt",   32'(resp_cnt),  1);
            @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // three-list instance: out-of-range list number
        issue3(2'd0, 2'd3, 8'h77, ok);
        chk("bad_ll_err",  32'(resp_err3),  3);
        chk("bad_ll_data", 32'(resp_data3), 0);
        chk("bad_ll_echo", 32'(resp_ll3),   3);
        chk("bad_ll_free", 32'(free_cnt3),  ND);
        issue3(2'd0, 2'd2, 8'h33, ok);
        chk("ll3_push_err",  32'(resp_err3), 0);
        chk("ll3_push_cnt",  32'(resp_cnt3), 1);
        chk("ll3_push_free", 32'(free_cnt3), ND - 1);
        issue3(2'd1, 2'd2, 8'h00, ok);
        chk("ll3_pop_data", 32'(resp_data3), 32'h33);
        chk("ll3_pop_cnt",  32'(resp_cnt3),  0);
        @(posedge clk); #1;

        // reset asserted while a PUSH is executing
        req_op = 2'd0; req_ll = 2'd0; req_data = 8'h99; req_vld = 1'b1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1; break; end
        end
        if (!ok) fail_now("rst_exec_accept_timeout");
        @(posedge clk); #1;
        req_vld = 1'b0;
        #1 reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) mq[i].delete();
        idle_free_exp = ND;
        chk("rst_exec_vld",   32'(resp_vld),  0);
        chk("rst_exec_ready", 32'(req_ready), 0);
        chk("rst_exec_free",  32'(free_cnt),  0);
        chk("rst_exec_done",  32'(init_done), 0);
        chk("rst_exec_data",  32'(resp_data), 0);
        chk("rst_exec_cnt",   32'(resp_cnt),  0);
        @(negedge clk);
        reset = 1'b0;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (init_done) begin ok = 1; break; end
        end
        if (!ok) fail_now("reinit_timeout");
        issue(2'd1, 0, 8'h00);
        drain();
        chk("reinit_free", 32'(free_cnt), ND);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
